bt_tx_fifo: RTL and testbench

BT_TX_FIFO -- requirements
Module: bt_tx_fifo

---
 rtl/bt_tx_fifo.sv | 135 +++++++++++++
 tb/tb_bt_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_tx_fifo.sv
// Byte FIFO feeding a UART transmitter.
// One byte is handed over per downstream frame.
module bt_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_data,
  output logic          tx_send,
  input  logic          tx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          ovf_q;
  logic          avail_q;
  logic [7:0]    data_q;
  logic          send_q;
  state_e        state_q;

  logic          wr_acc;
  logic          pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign tx_data  = data_q;
  assign tx_send  = send_q;

  // full is registered, so a pop never frees room
  // for a write in the same cycle
  assign wr_acc = wr_en & ~full;

  // a byte must sit one full cycle before it is
  // eligible, giving the two-edge write-to-send path
  assign pop = (state_q == IDLE) & avail_q &
               ~empty & ~tx_busy;

  // next occupancy and write pointer
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // pointers, occupancy, overflow pulse, eligibility
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= wr_en & full;
      avail_q  <= (count_q != '0);
    end
  end

  // feeder: pop in IDLE, hold request until busy,
  // then wait for the frame to finish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      data_q   <= 8'h00;
      send_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            data_q   <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            send_q   <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (tx_busy) begin
            send_q  <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          send_q <= 1'b0;
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          send_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bt_tx_fifo.sv
// Randomized bench for bt_tx_fifo with a queue
// reference model and a short-frame UART model.
module tb_bt_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          tx_busy = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_send;

  always #5 clk = ~clk;

  bt_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model: queue of stored bytes plus
  // the feeder phase (0 wait, 1 request, 2 frame)
  logic [7:0] mq[$];
  int         m_phase;
  int         m_old;
  logic       m_ovf;
  logic [7:0] m_data;
  logic [7:0] exp_rx[$];

  // downstream transmitter model
  logic [7:0] got_rx[$];
  bit         force_busy = 0;
  bit         mute = 0;
  int         frame_left = 0;
  int         fmin = 3;
  int         fmax = 6;
  int         n_frames = 0;
  int         n_rise = 0;

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_old   = 0;
    m_ovf   = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic busy_apply();
    tx_busy = (frame_left > 0) || force_busy;
  endtask

  task automatic check_all();
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("tx_send", tx_send, m_phase == 1);
    chk("tx_data", tx_data, m_data);
    chk("count_max", count <= DEPTH, 1);
  endtask

  task automatic step();
    logic       s_pre;
    logic [7:0] d_pre;
    logic       b;
    bit         acc;
    bit         drop;
    bit         pop;
    s_pre = tx_send;
    d_pre = tx_data;
    b     = tx_busy;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      acc  = wr_en && mq.size() < DEPTH;
      drop = wr_en && mq.size() == DEPTH;
      pop  = m_phase == 0 && m_old > 0 &&
             mq.size() > 0 && !b;
      m_old = mq.size();
      if (pop) begin
        m_data = mq.pop_front();
        exp_rx.push_back(m_data);
        m_phase = 1;
      end else if (m_phase == 1 && b) begin
        m_phase = 2;
      end else if (m_phase == 2 && !b) begin
        m_phase = 0;
      end
      if (acc) mq.push_back(wr_data);
      m_ovf = drop;
    end
    if (s_pre && !b && !mute && frame_left == 0) begin
      got_rx.push_back(d_pre);
      frame_left = $urandom_range(fmax, fmin);
      n_frames++;
    end
    if (frame_left > 0) frame_left--;
    #1;
    check_all();
    if (tx_send && !s_pre && !mute) n_rise++;
    busy_apply();
  endtask

  task automatic write(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit; i++) begin
      if (mq.size() == 0 && m_phase == 0 &&
          frame_left == 0 && !tx_busy) begin
        done = 1;
        break;
      end
      step();
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    logic [7:0] hold_d;
    int         rise0;
    int         n;
    model_reset();
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_data", tx_data, 8'h00);
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // single byte latency
    write(8'hA5);
    chk("sb_e0_send", tx_send, 0);
    step();
    chk("sb_e1_send", tx_send, 0);
    chk("sb_e1_count", count, 1);
    step();
    chk("sb_e2_send", tx_send, 1);
    chk("sb_e2_data", tx_data, 8'hA5);
    chk("sb_e2_empty", empty, 1);
    step();
    chk("sb_e3_send", tx_send, 1);
    step();
    chk("sb_e4_send", tx_send, 0);
    drain(200);

    // fill and overflow with the transmitter busy
    force_busy = 1;
    busy_apply();
    step();
    for (int i = 0; i <= DEPTH; i++) begin
      write(8'(i));
      chk("fill_ovf", overflow, i == DEPTH);
    end
    chk("fill_count", count, DEPTH);
    chk("fill_full", full, 1);
    step();
    chk("ovf_one_cycle", overflow, 0);
    force_busy = 0;
    busy_apply();
    n = got_rx.size();
    drain(400);
    chk("fill_rx_len", got_rx.size() - n, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (n + i < got_rx.size())
        chk("fill_rx_byte", got_rx[n + i], i);
    end

    // write on the same edge as the pop
    force_busy = 1;
    busy_apply();
    write(8'h11);
    write(8'h22);
    write(8'h33);
    step();
    step();
    force_busy = 0;
    busy_apply();
    write(8'h77);
    chk("rw_count", count, 3);
    chk("rw_ovf", overflow, 0);
    chk("rw_send", tx_send, 1);
    chk("rw_data", tx_data, 8'h11);
    drain(400);

    // reset in the middle of a request
    mute = 1;
    force_busy = 1;
    busy_apply();
    for (int i = 0; i < 6; i++) write(8'hC0 + 8'(i));
    step();
    force_busy = 0;
    busy_apply();
    step();
    chk("mid_send", tx_send, 1);
    chk("mid_count", count, 5);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_send", tx_send, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    model_reset();
    void'(exp_rx.pop_back());
    step();
    step();
    reset = 1'b1;
    mute = 0;
    rise0 = n_rise;
    repeat (20) step();
    chk("post_rst_quiet", n_rise, rise0);
    write(8'h5A);
    drain(200);
    chk("post_rst_send", n_rise, rise0 + 1);

    // long busy stall with two bytes queued
    force_busy = 1;
    busy_apply();
    write(8'h81);
    write(8'h82);
    hold_d = m_data;
    repeat (1000) step();
    chk("stall_data", tx_data, hold_d);
    chk("stall_count", count, 2);
    force_busy = 0;
    busy_apply();
    step();
    chk("stall_pop_send", tx_send, 1);
    chk("stall_pop_data", tx_data, 8'h81);
    chk("stall_pop_count", count, 1);
    drain(400);

    // randomized traffic through pointer wrap
    fmin = 2;
    fmax = 12;
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 300) % 2 == 0) ? 80 : 15;
      wr_en   = ($urandom_range(0, 99) < p);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 199) == 0)
        force_busy = !force_busy;
      busy_apply();
      step();
    end
    wr_en = 1'b0;
    force_busy = 0;
    busy_apply();
    drain(3000);

    chk("rx_len", got_rx.size(), exp_rx.size());
    n = (got_rx.size() < exp_rx.size()) ?
        got_rx.size() : exp_rx.size();
    for (int i = 0; i < n; i++)
      chk("rx_order", got_rx[i], exp_rx[i]);
    chk("send_per_frame", n_rise, n_frames);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
